// File: rtl/input_debouncer.sv
// Per-channel input conditioning: 2-flop synchroniser, stability-count debouncer,
// and registered one-cycle rising/falling edge pulses.
module input_debouncer #(
   parameter int unsigned N    = 4,
   parameter int unsigned WAIT = 3
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] noisy,
   output logic [N-1:0] conditioned,
   output logic [N-1:0] positive_edge,
   output logic [N-1:0] negative_edge
);

   localparam int unsigned CW = $clog2(WAIT + 1);
   localparam logic [CW-1:0] CntLast = CW'(WAIT - 1);

   logic [N-1:0]         s1_q, s2_q;
   logic [N-1:0]         cond_q, cond_d;
   logic [N-1:0]         pos_q, pos_d;
   logic [N-1:0]         neg_q, neg_d;
   logic [N-1:0][CW-1:0] cnt_q, cnt_d;

   // Only the second sync stage is observed; any match with the current level
   // discards the partial count, so short runs can never be accepted.
   always_comb begin
      cond_d = cond_q;
      pos_d  = '0;
      neg_d  = '0;
      cnt_d  = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (s2_q[i] != cond_q[i]) begin
            if (cnt_q[i] == CntLast) begin
               cond_d[i] = s2_q[i];
               pos_d[i]  = s2_q[i];
               neg_d[i]  = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q   <= '0;
         s2_q   <= '0;
         cnt_q  <= '0;
         cond_q <= '0;
         pos_q  <= '0;
         neg_q  <= '0;
      end else begin
         s1_q   <= noisy;
         s2_q   <= s1_q;
         cnt_q  <= cnt_d;
         cond_q <= cond_d;
         pos_q  <= pos_d;
         neg_q  <= neg_d;
      end
   end

   assign conditioned   = cond_q;
   assign positive_edge = pos_q;
   assign negative_edge = neg_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (N=4, WAIT=3): table of per-cycle vectors fed through
// an expectation queue, plus hand-written reset sequences.
module tb_input_debouncer;

   localparam int unsigned N    = 4;
   localparam int unsigned WAIT = 3;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] noisy = '0;
   logic [N-1:0] conditioned, positive_edge, negative_edge;

   input_debouncer #(.N(N), .WAIT(WAIT)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .noisy        (noisy),
      .conditioned  (conditioned),
      .positive_edge(positive_edge),
      .negative_edge(negative_edge)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] noisy;
      logic [3:0] cond;
      logic [3:0] pos;
      logic [3:0] neg;
   } vec_t;

   typedef struct {
      logic [3:0] cond;
      logic [3:0] pos;
      logic [3:0] neg;
      int         id;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input int id, input logic [3:0] got,
                        input logic [3:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s step %0d: got %h expected %h", name, id, got, want);
   endtask

   task automatic rows(input logic [3:0] v, input logic [3:0] c, input logic [3:0] p,
                       input logic [3:0] n, input int reps);
      vec_t r;
      r.noisy = v; r.cond = c; r.pos = p; r.neg = n;
      for (int k = 0; k < reps; k++) tbl.push_back(r);
   endtask

   task automatic zero_check(input string name, input int id);
      check({name, "_cond"}, id, conditioned, 4'h0);
      check({name, "_pos"}, id, positive_edge, 4'h0);
      check({name, "_neg"}, id, negative_edge, 4'h0);
   endtask

   // Drive one vector, queue its expectation, and compare after the next edge.
   task automatic apply(input vec_t r, input int id);
      exp_t e;
      noisy  = r.noisy;
      e.cond = r.cond; e.pos = r.pos; e.neg = r.neg; e.id = id;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard step %0d: got empty queue expected entry", id);
      end else begin
         e = sb.pop_front();
         check("conditioned", e.id, conditioned, e.cond);
         check("positive_edge", e.id, positive_edge, e.pos);
         check("negative_edge", e.id, negative_edge, e.neg);
         check("pulse_overlap", e.id, positive_edge & negative_edge, 4'h0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int id;
      // Reset held with all inputs high: everything stays clear.
      reset_n = 1'b0;
      noisy   = 4'hF;
      #1;
      zero_check("reset_async", 0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         zero_check("reset_hold", k);
      end
      reset_n = 1'b1;

      // Release with inputs high, then return to zero.
      rows(4'hF, 4'h0, 4'h0, 4'h0, 4);
      rows(4'hF, 4'hF, 4'hF, 4'h0, 1);
      rows(4'hF, 4'hF, 4'h0, 4'h0, 1);
      rows(4'h0, 4'hF, 4'h0, 4'h0, 4);
      rows(4'h0, 4'h0, 4'h0, 4'hF, 1);
      rows(4'h0, 4'h0, 4'h0, 4'h0, 1);
      // Clean press and release on channel 0.
      rows(4'h1, 4'h0, 4'h0, 4'h0, 4);
      rows(4'h1, 4'h1, 4'h1, 4'h0, 1);
      rows(4'h1, 4'h1, 4'h0, 4'h0, 2);
      rows(4'h0, 4'h1, 4'h0, 4'h0, 4);
      rows(4'h0, 4'h0, 4'h0, 4'h1, 1);
      rows(4'h0, 4'h0, 4'h0, 4'h0, 1);
      // Bounce on channel 1, then a stable high.
      rows(4'h2, 4'h0, 4'h0, 4'h0, 1);
      rows(4'h0, 4'h0, 4'h0, 4'h0, 1);
      rows(4'h2, 4'h0, 4'h0, 4'h0, 1);
      rows(4'h0, 4'h0, 4'h0, 4'h0, 1);
      rows(4'h2, 4'h0, 4'h0, 4'h0, 4);
      rows(4'h2, 4'h2, 4'h2, 4'h0, 1);
      rows(4'h2, 4'h2, 4'h0, 4'h0, 1);
      // Two-cycle glitch on channel 2 (one short of WAIT) is rejected.
      rows(4'h6, 4'h2, 4'h0, 4'h0, 2);
      rows(4'h2, 4'h2, 4'h0, 4'h0, 5);
      // Back to zero, then simultaneous multi-channel changes.
      rows(4'h0, 4'h2, 4'h0, 4'h0, 4);
      rows(4'h0, 4'h0, 4'h0, 4'h2, 1);
      rows(4'h0, 4'h0, 4'h0, 4'h0, 1);
      rows(4'hA, 4'h0, 4'h0, 4'h0, 4);
      rows(4'hA, 4'hA, 4'hA, 4'h0, 1);
      rows(4'hA, 4'hA, 4'h0, 4'h0, 1);
      rows(4'h5, 4'hA, 4'h0, 4'h0, 4);
      rows(4'h5, 4'h5, 4'h5, 4'hA, 1);
      rows(4'h5, 4'h5, 4'h0, 4'h0, 1);
      // Channel 3 rises; three edges into its debounce.
      rows(4'hD, 4'h5, 4'h0, 4'h0, 3);

      id = 1;
      foreach (tbl[k]) begin
         apply(tbl[k], id);
         id++;
      end

      // Half-cycle reset pulse mid-debounce clears outputs without a clock edge.
      reset_n = 1'b0;
      #1;
      zero_check("midreset_async", id);
      @(negedge clk);
      reset_n = 1'b1;

      tbl.delete();
      rows(4'hD, 4'h0, 4'h0, 4'h0, 4);
      rows(4'hD, 4'hD, 4'hD, 4'h0, 1);
      rows(4'hD, 4'hD, 4'h0, 4'h0, 1);
      foreach (tbl[k]) begin
         apply(tbl[k], id);
         id++;
      end

      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions the raw ZYBO button and switch lines before they reach the operand-load and display-select wrapper. Per channel it does three things:
- Synchronises the asynchronous input into the clk domain with a 2-flop chain.
- Debounces it with a per-channel stability counter.
- Emits a clean level plus one-cycle rising and falling pulses.

The wrapper's enable-gated operand registers and select flip-flop consume these outputs instead of the raw pins.

Parameters:
N, 4, number of independent input channels (buttons or switches)
WAIT, 3, consecutive clk cycles a synchronised value must differ from the current conditioned value before it is accepted; legal range 1..255
CW, $clog2(WAIT+1), counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all state updates on posedge
reset_n  input  1  asynchronous active-low reset
noisy  input  N  raw asynchronous inputs, bit i = channel i
conditioned  output  N  debounced level per channel
positive_edge  output  N  one-cycle pulse when conditioned[i] goes 0->1
negative_edge  output  N  one-cycle pulse when conditioned[i] goes 1->0

Behaviour:
- Reset: reset_n is asynchronous and active-low. While low, every flop clears immediately, independent of clk:
  - sync stages, counters, conditioned, positive_edge and negative_edge are all 0.
  - This holds mid-debounce and mid-pulse: an in-progress pulse is truncated and the count is lost.
- Release: the first state update occurs on the first posedge clk after reset_n rises.
- Synchroniser, per channel:
  - s1[i] <= noisy[i]; s2[i] <= s1[i].
  - Only s2 feeds the debounce logic; noisy never reaches it combinationally.
- Debounce, per channel, evaluated each posedge. Channels are fully independent; no shared counter.
  - s2 == conditioned: cnt <= 0; conditioned holds; no pulse.
  - s2 != conditioned and cnt == WAIT-1: conditioned <= s2; cnt <= 0; pulse fires (see below).
  - s2 != conditioned and cnt < WAIT-1: cnt <= cnt+1.
- Pulse timing:
  - positive_edge[i]/negative_edge[i] are registered. They are asserted on the same edge conditioned[i] updates and deasserted on the next edge.
  - Exactly 1 cycle high, coincident with the first cycle of the new conditioned value.
  - positive_edge[i] and negative_edge[i] are never high together.
- Latency:
  - noisy[i] changes and stays stable before posedge 1.
  - s2 reflects it after posedge 2.
  - conditioned[i] and the pulse update at posedge 2+WAIT (WAIT=3 gives posedge 5).
- Glitch rejection:
  - Any return of s2 to the conditioned value before the count completes resets cnt to 0 and produces no output change.
  - The next mismatch restarts counting from 0.
  - A stable run of fewer than WAIT synchronised cycles is never accepted.
- Back-to-back transitions: the minimum spacing between successive pulses on one channel is WAIT cycles, because each accepted change restarts the count from 0.
- Counter bound: cnt never exceeds WAIT-1; no wrap-around is possible.
- Simultaneous events: all N channels may accept changes on the same edge; each produces its own pulse independently.

Test Plan:
All scenarios use N=4, WAIT=3.
- Reset: hold reset_n=0 with noisy=4'hF for 5 cycles -> conditioned, positive_edge and negative_edge all 0. Release -> conditioned[3:0]=4'hF at posedge 5 after release, positive_edge=4'hF for exactly that one cycle.
- Clean press: noisy[0] 0->1 before posedge 1, then held -> conditioned[0]=1 after posedge 5; positive_edge[0]=1 only in cycle 5-6; other bits unchanged. Release later -> negative_edge[0] one-cycle pulse 5 edges after the change.
- Bounce: noisy[1] toggles 1,0,1,0 on successive cycles, then holds 1 -> no output change during toggling; conditioned[1]=1 exactly 2+3 edges after the final stable 1 is sampled; a single positive_edge[1] pulse.
- Short glitch: noisy[2] high for 2 cycles, then low -> conditioned[2] stays 0; no pulses.
- Simultaneous channels: noisy 4'h0->4'hA -> conditioned=4'hA and positive_edge=4'hA on the same edge. Then 4'hA->4'h5 -> positive_edge=4'h5 and negative_edge=4'hA on the same edge.
- Mid-debounce reset: noisy[3] rises; pulse reset_n low for half a cycle after posedge 3 -> all outputs 0 asynchronously; count restarts, and conditioned[3]=1 at posedge 5 after release.
